regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised, multi-read-port register file for the MIPS_32 core. It is the successor of the single-read-pair register block.
- Writes are clocked: one main write port with byte-lane enables for lb/lh/full-word, plus a dedicated link-register write port for jal.
- Reads are registered, with a 1-cycle latency, and gated by a read enable. When the read enable is low, the outputs hold.
- Sits between decode (addresses, opcode-derived controls) and the ALU/writeback stages.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- DEPTH, 32, number of architectural registers; power of two, at least 2.
- NUM_RD, 2, number of read ports, from 1 to 4.
- LINK_REG, 31, index written by the link port.
- LINK_OFFSET, 4, constant added to link_pc before it is stored.

Derived: ADDR_W = clog2(DEPTH); NB = DATA_W/8.

Ports:
- clk  in  1  system clock, rising edge active
- rst  in  1  asynchronous reset, active-high
- rd_en  in  1  capture read data this cycle
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- rd_valid  out  1  high the cycle after a captured read
- wr_en  in  1  main write strobe
- wr_addr  in  ADDR_W  main write index (rt or rd, selected upstream)
- wr_be  in  NB  byte-lane enables; lane k maps to bits [8k+7:8k]
- wr_data  in  DATA_W  write data, LSB-aligned
- link_en  in  1  jal link write strobe
- link_pc  in  DATA_W  PC of the jal instruction
- wr_err  out  1  sticky flag: an illegal write was attempted

Behaviour:
- Reset (async, rst=1): all DEPTH entries go to 0; rd_data=0; rd_valid=0; wr_err=0. Release is sampled on the next rising clk. A write or read active in the reset cycle is discarded.
- Register 0 reads as 0 always. Writes to index 0 are dropped silently and do not set wr_err.
- Main write, at posedge with wr_en=1:
  - For each lane k with wr_be[k]=1, mem[wr_addr] lane k takes wr_data lane k.
  - Lanes with wr_be[k]=0 are unchanged. This gives lb = lane 0 only, lh = lanes 0–1, word/lui = all lanes.
  - wr_be = 0 with wr_en=1 means no change, and sets wr_err.
- Link write, at posedge with link_en=1: mem[LINK_REG] gets link_pc + LINK_OFFSET, modulo 2^DATA_W (wraps).
- Simultaneous main write and link write:
  - If wr_addr differs from LINK_REG, both take effect.
  - If wr_addr equals LINK_REG, the main write's enabled lanes win; the remaining lanes take the link value. wr_err is set in this case.
- Read, at posedge with rd_en=1:
  - For each port i, rd_data[i] gets mem[rd_addr[i]], with the optional bypass applied.
  - rd_valid is 1 in the next cycle.
- Read, at posedge with rd_en=0: rd_data holds its value; rd_valid goes to 0.
- Ports reading the same address return identical data.
- Read/write ordering without bypass: a read in the same cycle as a write to the same address returns the pre-write value. The new value is visible from the next read cycle.
- wr_err clears only on reset.
- Latency: write takes effect at the edge; read data is available 1 cycle after the rd_en edge.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: a same-cycle read of an address being written returns the post-write merged value. The merge covers main lanes over link over the old contents. Index 0 still reads 0.
- Undefined: no forwarding; the read returns the old contents. This removes the bypass comparators and muxes.

Decomposition:
- Package regfile_pkg holds:
  - lane-mask constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111 (for DATA_W=32);
  - default LINK_REG and LINK_OFFSET constants;
  - a function clog2.
- Sub-module regfile_lane_merge (combinational): inputs old word, new word, be; output merged word. It is reused by the write path and the bypass path.

Test Plan:
- Reset: set rst=1 mid-operation after writing 0xDEADBEEF to r5; release; read r5 -> rd_data=0, rd_valid=0 during reset, wr_err=0.
- Byte-lane writes:
  - word-write r3=0x11223344;
  - lb write 0x000000AA with be=0001 gives r3=0x112233AA;
  - lh write 0x0000BEEF with be=0011 gives r3=0x1122BEEF;
  - read r3 on both ports -> both return 0x1122BEEF one cycle later.
- r0 and link:
  - write 0xFFFFFFFF to r0 -> reads 0, wr_err stays 0;
  - link_en with link_pc=0x00400010 -> r31=0x00400014;
  - link_pc=0xFFFFFFFC -> r31=0x00000000 (wrap).
- Collision: wr_en to r31 with be=0001 and data=0x55, plus link_pc=0x100, in the same cycle -> r31=0x00000155, wr_err=1 (sticky until rst).
- Read hold/bypass:
  - rd_en=0 after a read of r3 -> rd_data unchanged, rd_valid=0;
  - same-cycle write r7=0x12345678 and read r7 -> returns old value 0, or 0x12345678 with REGFILE_BYPASS_EN.
- Parametrisation: DATA_W=64, DEPTH=16, NUM_RD=3 -> word and byte writes are correct on every lane, and three independent read addresses return the correct registers.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-read-port register file.
package regfile_pkg;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam int unsigned LINK_REG_DEF    = 31;
  localparam int unsigned LINK_OFFSET_DEF = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/link bus between decode and the register file.
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2
);
  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned NB     = DATA_W / 8;

  logic                       rd_en;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic                       rd_valid;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [NB-1:0]              wr_be;
  logic [DATA_W-1:0]          wr_data;
  logic                       link_en;
  logic [DATA_W-1:0]          link_pc;
  logic                       wr_err;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data, link_en, link_pc,
    input  rd_data, rd_valid, wr_err
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data, link_en, link_pc,
    output rd_data, rd_valid, wr_err
  );

endinterface

// File: rtl/regfile_lane_merge.sv
// Byte-lane merge: enabled lanes take the new word, others keep the old word.
module regfile_lane_merge #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_i,
  input  logic [DATA_W-1:0]   new_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   merged_o
);

  for (genvar k = 0; k < DATA_W / 8; k++) begin : g_lane
    assign merged_o[8*k +: 8] = be_i[k] ? new_i[8*k +: 8] : old_i[8*k +: 8];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-lane writes and a jal link port.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp import regfile_pkg::*; #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned LINK_REG    = LINK_REG_DEF,
  parameter int unsigned LINK_OFFSET = LINK_OFFSET_DEF
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DATA_W-1:0]        mem_d [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic                     rd_valid_q;
  logic                     wr_err_q, wr_err_d;

  logic [DATA_W-1:0] link_val, wr_old, wr_merged;
  logic              link_hit, wr_live;
  logic [ADDR_W-1:0] ra;

  assign link_val = bus.link_pc + DATA_W'(LINK_OFFSET);
  assign link_hit = bus.link_en && (bus.wr_addr == LINK_IDX);
  assign wr_live  = bus.wr_en && (bus.wr_addr != '0);
  // On a collision the main write merges over the link value, not the old entry.
  assign wr_old   = link_hit ? link_val : mem_q[bus.wr_addr];

  regfile_lane_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .old_i    (wr_old),
    .new_i    (bus.wr_data),
    .be_i     (bus.wr_be),
    .merged_o (wr_merged)
  );

  always_comb begin
    mem_d = mem_q;
    if (bus.link_en && (LINK_IDX != '0)) mem_d[LINK_IDX] = link_val;
    if (wr_live) mem_d[bus.wr_addr] = wr_merged;
    wr_err_d = wr_err_q | (wr_live && ((bus.wr_be == '0) || link_hit));
  end

  always_comb begin
    rd_data_d = rd_data_q;
    ra        = '0;
    if (bus.rd_en) begin
      for (int i = 0; i < int'(NUM_RD); i++) begin
        ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        rd_data_d[i*DATA_W +: DATA_W] = mem_d[ra];
`else
        rd_data_d[i*DATA_W +: DATA_W] = mem_q[ra];
`endif
      end
    end
  end

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < int'(DEPTH); j++) mem_q[j] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      for (int j = 0; j < int'(DEPTH); j++) mem_q[j] <= mem_d[j];
      rd_data_q  <= rd_data_d;
      rd_valid_q <= bus.rd_en;
      wr_err_q   <= wr_err_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: 32-bit/2-port and 64-bit/3-port instances.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) b32 ();
  regfile_mp_if #(.DATA_W(64), .DEPTH(16), .NUM_RD(3)) b64 ();

  regfile_mp #(
    .DATA_W(32), .DEPTH(32), .NUM_RD(2), .LINK_REG(31), .LINK_OFFSET(4)
  ) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32)
  );

  regfile_mp #(
    .DATA_W(64), .DEPTH(16), .NUM_RD(3), .LINK_REG(14), .LINK_OFFSET(4)
  ) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b32.rd_en = 1'b0; b32.rd_addr = '0; b32.wr_en = 1'b0; b32.wr_addr = '0;
    b32.wr_be = '0; b32.wr_data = '0; b32.link_en = 1'b0; b32.link_pc = '0;
    b64.rd_en = 1'b0; b64.rd_addr = '0; b64.wr_en = 1'b0; b64.wr_addr = '0;
    b64.wr_be = '0; b64.wr_data = '0; b64.link_en = 1'b0; b64.link_pc = '0;
  endtask

  task automatic wr32(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    b32.wr_en = 1'b1; b32.wr_addr = a; b32.wr_data = d; b32.wr_be = be;
    tick();
    b32.wr_en = 1'b0; b32.wr_be = '0;
  endtask

  task automatic rd32(input logic [4:0] a0, input logic [4:0] a1);
    b32.rd_en = 1'b1; b32.rd_addr = {a1, a0};
    tick();
    b32.rd_en = 1'b0;
  endtask

  task automatic link32(input logic [31:0] pc);
    b32.link_en = 1'b1; b32.link_pc = pc;
    tick();
    b32.link_en = 1'b0;
  endtask

  task automatic wr64(input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
    b64.wr_en = 1'b1; b64.wr_addr = a; b64.wr_data = d; b64.wr_be = be;
    tick();
    b64.wr_en = 1'b0; b64.wr_be = '0;
  endtask

  task automatic rd64(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    b64.rd_en = 1'b1; b64.rd_addr = {a2, a1, a0};
    tick();
    b64.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    wr32(5'd5, 32'hDEADBEEF, 4'hF);
    wr32(5'd6, 32'h0000_1234, 4'h0);
    rd32(5'd5, 5'd5);
    n_checks++;
    if (b32.rd_data[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL pre_reset_r5: got %h expected %h", b32.rd_data[31:0], 32'hDEADBEEF);
    end
    n_checks++;
    if (b32.wr_err !== 1'b1) begin
      n_fail++; $display("FAIL be0_sets_err: got %b expected 1", b32.wr_err);
    end
    // Reset mid-operation with a read and a write active.
    b32.rd_en = 1'b1; b32.rd_addr = {5'd5, 5'd5};
    b32.wr_en = 1'b1; b32.wr_addr = 5'd5; b32.wr_data = 32'hCAFEF00D; b32.wr_be = 4'hF;
    rst = 1'b1;
    #1;
    n_checks++;
    if (b32.rd_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_rd_data: got %h expected 0", b32.rd_data);
    end
    n_checks++;
    if (b32.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", b32.rd_valid);
    end
    n_checks++;
    if (b32.wr_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_wr_err: got %b expected 0", b32.wr_err);
    end
    tick();
    idle();
    rst = 1'b0;
    rd32(5'd5, 5'd6);
    n_checks++;
    if (b32.rd_data !== 64'h0) begin
      n_fail++; $display("FAIL post_reset_r5_r6: got %h expected 0", b32.rd_data);
    end
    n_checks++;
    if (b32.rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_valid: got %b expected 1", b32.rd_valid);
    end
  endtask

  task automatic test_byte_lanes();
    wr32(5'd3, 32'h11223344, 4'hF);
    wr32(5'd3, 32'h000000AA, 4'h1);
    rd32(5'd3, 5'd0);
    n_checks++;
    if (b32.rd_data[31:0] !== 32'h112233AA) begin
      n_fail++; $display("FAIL lb_r3: got %h expected %h", b32.rd_data[31:0], 32'h112233AA);
    end
    wr32(5'd3, 32'h0000BEEF, 4'h3);
    rd32(5'd3, 5'd3);
    n_checks++;
    if (b32.rd_data[31:0] !== 32'h1122BEEF) begin
      n_fail++; $display("FAIL lh_r3_p0: got %h expected %h", b32.rd_data[31:0], 32'h1122BEEF);
    end
    n_checks++;
    if (b32.rd_data[63:32] !== 32'h1122BEEF) begin
      n_fail++; $display("FAIL lh_r3_p1: got %h expected %h", b32.rd_data[63:32], 32'h1122BEEF);
    end
  endtask

  task automatic test_r0_link();
    wr32(5'd0, 32'hFFFFFFFF, 4'hF);
    rd32(5'd0, 5'd0);
    n_checks++;
    if (b32.rd_data !== 64'h0) begin
      n_fail++; $display("FAIL r0_reads_zero: got %h expected 0", b32.rd_data);
    end
    n_checks++;
    if (b32.wr_err !== 1'b0) begin
      n_fail++; $display("FAIL r0_no_err: got %b expected 0", b32.wr_err);
    end
    link32(32'h00400010);
    rd32(5'd31, 5'd3);
    n_checks++;
    if (b32.rd_data[31:0] !== 32'h00400014) begin
      n_fail++; $display("FAIL link_r31: got %h expected %h", b32.rd_data[31:0], 32'h00400014);
    end
    link32(32'hFFFFFFFC);
    rd32(5'd3, 5'd31);
    n_checks++;
    if (b32.rd_data[63:32] !== 32'h00000000) begin
      n_fail++; $display("FAIL link_wrap: got %h expected 0", b32.rd_data[63:32]);
    end
  endtask

  task automatic test_collision();
    b32.link_en = 1'b1; b32.link_pc = 32'h00000100;
    wr32(5'd31, 32'h00000055, 4'h1);
    b32.link_en = 1'b0;
    rd32(5'd31, 5'd31);
    n_checks++;
    if (b32.rd_data[31:0] !== 32'h00000155) begin
      n_fail++; $display("FAIL collision_r31: got %h expected %h", b32.rd_data[31:0], 32'h155);
    end
    n_checks++;
    if (b32.wr_err !== 1'b1) begin
      n_fail++; $display("FAIL collision_err: got %b expected 1", b32.wr_err);
    end
  endtask

  task automatic test_read_hold();
    rd32(5'd3, 5'd31);
    b32.rd_addr = {5'd0, 5'd7};
    tick();
    n_checks++;
    if (b32.rd_data !== {32'h00000155, 32'h1122BEEF}) begin
      n_fail++; $display("FAIL hold_data: got %h expected %h", b32.rd_data,
                         {32'h00000155, 32'h1122BEEF});
    end
    n_checks++;
    if (b32.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_valid: got %b expected 0", b32.rd_valid);
    end
    n_checks++;
    if (b32.wr_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b expected 1", b32.wr_err);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_r7;
`ifdef REGFILE_BYPASS_EN
    exp_r7 = 32'h12345678;
`else
    exp_r7 = 32'h00000000;
`endif
    b32.rd_en = 1'b1; b32.rd_addr = {5'd3, 5'd7};
    wr32(5'd7, 32'h12345678, 4'hF);
    b32.rd_en = 1'b0;
    n_checks++;
    if (b32.rd_data[31:0] !== exp_r7) begin
      n_fail++; $display("FAIL same_cycle_r7: got %h expected %h", b32.rd_data[31:0], exp_r7);
    end
    n_checks++;
    if (b32.rd_data[63:32] !== 32'h1122BEEF) begin
      n_fail++; $display("FAIL same_cycle_r3: got %h expected %h", b32.rd_data[63:32],
                         32'h1122BEEF);
    end
    rd32(5'd7, 5'd7);
    n_checks++;
    if (b32.rd_data[31:0] !== 32'h12345678) begin
      n_fail++; $display("FAIL r7_next_read: got %h expected %h", b32.rd_data[31:0],
                         32'h12345678);
    end
  endtask

  task automatic test_param64();
    wr64(4'd1, 64'h0123456789ABCDEF, 8'hFF);
    wr64(4'd2, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    wr64(4'd2, 64'h0000000000000055, 8'h01);
    wr64(4'd2, 64'h7700000000000000, 8'h80);
    wr64(4'd2, 64'h000000CC00000000, 8'h10);
    wr64(4'd15, 64'hFEDCBA9876543210, 8'hFF);
    b64.link_en = 1'b1; b64.link_pc = 64'hFFFFFFFFFFFFFFFE;
    tick();
    b64.link_en = 1'b0;
    rd64(4'd1, 4'd2, 4'd15);
    n_checks++;
    if (b64.rd_data[63:0] !== 64'h0123456789ABCDEF) begin
      n_fail++; $display("FAIL w64_r1: got %h expected %h", b64.rd_data[63:0], 64'h0123456789ABCDEF);
    end
    n_checks++;
    if (b64.rd_data[127:64] !== 64'h77AAAACCAAAAAA55) begin
      n_fail++; $display("FAIL w64_r2_lanes: got %h expected %h", b64.rd_data[127:64],
                         64'h77AAAACCAAAAAA55);
    end
    n_checks++;
    if (b64.rd_data[191:128] !== 64'hFEDCBA9876543210) begin
      n_fail++; $display("FAIL w64_r15: got %h expected %h", b64.rd_data[191:128],
                         64'hFEDCBA9876543210);
    end
    rd64(4'd14, 4'd0, 4'd1);
    n_checks++;
    if (b64.rd_data !== {64'h0123456789ABCDEF, 64'h0, 64'h2}) begin
      n_fail++; $display("FAIL w64_link_r0_r1: got %h expected %h", b64.rd_data,
                         {64'h0123456789ABCDEF, 64'h0, 64'h2});
    end
    n_checks++;
    if (b64.wr_err !== 1'b0) begin
      n_fail++; $display("FAIL w64_err: got %b expected 0", b64.wr_err);
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_r0_link();
    test_collision();
    test_read_hold();
    test_bypass();
    test_param64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
